lfsr16_stepper: RTL and testbench
=================================

# lfsr16_stepper

Sequential source for the 16-bit LFSR display path on the DE2-115. It holds a 16-bit maximal-length Fibonacci LFSR and advances it either from an internal prescaled tick while running, or one step per request while paused. It exposes the state as four 4-bit nibbles that feed the four hex-digit seven-segment decoders directly downstream. It also reports step pulses, a step count and full-period completion.

## Interface
Parameters:
- TICK_DIV, 50000000, clock cycles per automatic step while running (≥1; 1 = step every cycle)
- DEFAULT_SEED, 16'hACE1, reset value and substitute for an all-zero seed (must be nonzero)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- run_toggle  in  1  single-cycle pulse; toggles running/paused
- step_req  in  1  single-cycle pulse; advances one step when paused
- load  in  1  single-cycle pulse; loads seed
- seed  in  16  seed value sampled when load=1
- lfsr_q  out  16  current LFSR state
- hex3, hex2, hex1, hex0  out  4 each  lfsr_q[15:12], [11:8], [7:4], [3:0] (wires, feed decoders)
- running  out  1  1 = auto-stepping
- step_pulse  out  1  high for one cycle after each advance
- step_cnt  out  16  advances since last load/reset/period wrap
- period_done  out  1  high for one cycle when state returns to start value

## Operation
- Polynomial x^16+x^14+x^13+x^11+1. fb = q[15]^q[13]^q[12]^q[10]. Advance: q <= {q[14:0], fb}.
- Internal registers: start_val (16), prescaler (ceil(log2(TICK_DIV)) bits, min 1).
- Priority per edge: rst > load > advance. run_toggle is independent of load and advance.
- load: q <= (seed==0 ? DEFAULT_SEED : seed). start_val gets the same value. step_cnt <= 0, prescaler <= 0. No step_pulse on a load edge.
- tick = running && prescaler==TICK_DIV-1. While running, prescaler counts 0..TICK_DIV-1 and wraps to 0. While paused, prescaler holds at 0.
- advance = !load && (tick || (!running && step_req)). step_req while running is ignored. Requests are not queued.
- On an advance:
  - step_pulse <= 1.
  - If the next state equals start_val: period_done <= 1 and step_cnt <= 0.
  - Otherwise: step_cnt <= step_cnt+1, wrapping 65535→0.
- Lock-up guard: if q==0 at an advance, q <= DEFAULT_SEED. This state is unreachable in normal operation and exists as a defensive recovery only.
- run_toggle: running <= ~running and prescaler <= 0. The first auto step occurs TICK_DIV cycles after the toggle edge.
- Simultaneous run_toggle and step_req while paused: the step is taken using the pre-toggle state (paused), and running becomes 1.
- Reset values: lfsr_q=DEFAULT_SEED, start_val=DEFAULT_SEED, running=0, step_cnt=0, step_pulse=0, period_done=0, prescaler=0. Reset mid-run aborts with no pulses.

## Timing
- All outputs are registered except hex3..hex0, which are pure slices of lfsr_q.
- Latency from step_req/load/run_toggle asserted at edge N to the new lfsr_q/running value: 1 cycle (visible after edge N).
- step_pulse and period_done are high in the same cycle the new lfsr_q is visible. They are low in every other cycle.
- Running, TICK_DIV=D: advances are exactly D cycles apart.
- Maximal length: period_done fires on every 65535th advance. step_cnt reads 65534 immediately before the wrap advance.

## Test plan
- Reset, then hold inputs idle for 100 cycles → lfsr_q=16'hACE1, hex3..0=A,C,E,1, running=0, step_cnt=0, no pulses.
- load seed=16'hACE1, then step_req twice while paused → lfsr_q 16'h59C3 then 16'hB387, step_pulse once per step, step_cnt=2.
- load seed=0 → lfsr_q=16'hACE1, step_cnt=0. Then load together with step_req → loaded value only, no step_pulse.
- TICK_DIV=4, run_toggle → first advance 4 cycles after the toggle edge, then every 4 cycles. Second run_toggle → stepping stops and step_req works again.
- TICK_DIV=1, running from seed 16'h0001 → period_done high only on advance 65535 with lfsr_q=16'h0001 and step_cnt=0. No intermediate state is 0, and no state repeats before then.
- Assert rst mid-run with prescaler nonzero → next cycle shows all reset values and no stray step_pulse.

Source files
------------

// File: rtl/lfsr16_stepper_if.sv
// Control inputs and display/status outputs of the 16-bit LFSR stepper.
// The bench or controller uses the master modport. The stepper uses the slave modport.
interface lfsr16_stepper_if;
  logic        run_toggle;
  logic        step_req;
  logic        load;
  logic [15:0] seed;
  logic [15:0] lfsr_q;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;
  logic        running;
  logic        step_pulse;
  logic [15:0] step_cnt;
  logic        period_done;

  modport master (
    output run_toggle, step_req, load, seed,
    input  lfsr_q, hex3, hex2, hex1, hex0, running, step_pulse, step_cnt, period_done
  );

  modport slave (
    input  run_toggle, step_req, load, seed,
    output lfsr_q, hex3, hex2, hex1, hex0, running, step_pulse, step_cnt, period_done
  );
endinterface

// File: rtl/lfsr16_stepper.sv
// 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for the hex display path.
// It steps from a prescaled tick while running, or once per request while paused.
module lfsr16_stepper #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  lfsr16_stepper_if.slave bus
);
  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [15:0]   q;
  logic [15:0]   start_val;
  logic [15:0]   step_cnt;
  logic [PW-1:0] prescaler;
  logic          running;
  logic          step_pulse;
  logic          period_done;
  logic          tick;
  logic          advance;
  logic [15:0]   seed_eff;
  logic [15:0]   q_next;

  // An all-zero state would lock up, so it recovers to the default seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s == 16'h0000) return DEFAULT_SEED;
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_comb begin
    tick     = running && (prescaler == PRESC_LAST);
    advance  = !bus.load && (tick || (!running && bus.step_req));
    seed_eff = (bus.seed == 16'h0000) ? DEFAULT_SEED : bus.seed;
    q_next   = lfsr_next(q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= DEFAULT_SEED;
      start_val   <= DEFAULT_SEED;
      step_cnt    <= 16'd0;
      prescaler   <= '0;
      running     <= 1'b0;
      step_pulse  <= 1'b0;
      period_done <= 1'b0;
    end else begin
      step_pulse  <= 1'b0;
      period_done <= 1'b0;

      if (bus.run_toggle) running <= ~running;

      // The advance is decided on the pre-toggle running value. A toggle restarts the count.
      if (bus.run_toggle || bus.load || !running || tick) prescaler <= '0;
      else                                                prescaler <= prescaler + PW'(1);

      if (bus.load) begin
        q         <= seed_eff;
        start_val <= seed_eff;
        step_cnt  <= 16'd0;
      end else if (advance) begin
        q          <= q_next;
        step_pulse <= 1'b1;
        if (q_next == start_val) begin
          period_done <= 1'b1;
          step_cnt    <= 16'd0;
        end else begin
          step_cnt <= step_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.lfsr_q      = q;
  assign bus.hex3        = q[15:12];
  assign bus.hex2        = q[11:8];
  assign bus.hex1        = q[7:4];
  assign bus.hex0        = q[3:0];
  assign bus.running     = running;
  assign bus.step_pulse  = step_pulse;
  assign bus.step_cnt    = step_cnt;
  assign bus.period_done = period_done;
endmodule

// File: tb/tb_lfsr16_stepper.sv
// Bench for lfsr16_stepper: a TICK_DIV=4 instance for the stepping and run-control cases, and a
// TICK_DIV=1 instance for the full-period run. Advances are scoreboarded against a reference model.
module tb_lfsr16_stepper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr16_stepper_if ia();
  lfsr16_stepper_if ib();

  lfsr16_stepper #(.TICK_DIV(4), .DEFAULT_SEED(16'hACE1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  lfsr16_stepper #(.TICK_DIV(1), .DEFAULT_SEED(16'hACE1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed { logic [15:0] q; logic [15:0] cnt; } adv_t;
  adv_t sb_q[$];

  typedef struct {
    logic tgl, step, ld;
    logic [15:0] seed;
    logic [15:0] q;
    logic pulse;
    logic [15:0] cnt;
    logic run;
  } vec_t;
  vec_t tbl[10];

  bit seen [65536];

  function automatic logic [15:0] model_next(input logic [15:0] s);
    if (s == 16'h0000) return 16'hACE1;
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_adv(input logic [15:0] q, input logic [15:0] cnt);
    adv_t e;
    e.q   = q;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ia.run_toggle = 1'b0; ia.step_req = 1'b0; ia.load = 1'b0; ia.seed = 16'h0000;
    ib.run_toggle = 1'b0; ib.step_req = 1'b0; ib.load = 1'b0; ib.seed = 16'h0000;
  endtask

  // Every step pulse from instance A must match the oldest pending expected advance.
  always @(negedge clk) begin : mon
    adv_t e;
    if (rst === 1'b0 && ia.step_pulse === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected_pulse: got pulse with q=%0h, want no pulse", ia.lfsr_q);
      end else begin
        e = sb_q.pop_front();
        check("sb_q", 32'(ia.lfsr_q), 32'(e.q));
        check("sb_cnt", 32'(ia.step_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [15:0] s1, s2, s3, e1, e2, e3, prev, cur, cnt34;
    int np, miss, model_err, zero_seen, rep, pd_cnt, pd_n;

    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    np = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (ia.step_pulse || ia.period_done || ib.step_pulse || ib.period_done) np++;
    end
    check("idle_pulses", 32'(np), 0);
    check("rst_q_a", 32'(ia.lfsr_q), 32'h0000ACE1);
    check("rst_hex_a", 32'({ia.hex3, ia.hex2, ia.hex1, ia.hex0}), 32'h0000ACE1);
    check("rst_run_a", 32'(ia.running), 0);
    check("rst_cnt_a", 32'(ia.step_cnt), 0);
    check("rst_q_b", 32'(ib.lfsr_q), 32'h0000ACE1);

    s1 = model_next(16'h1234);
    s2 = model_next(s1);
    s3 = model_next(s2);
    tbl[0] = '{1'b0, 1'b0, 1'b1, 16'hACE1, 16'hACE1, 1'b0, 16'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h59C3, 1'b1, 16'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hB387, 1'b1, 16'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'hB387, 1'b0, 16'd2, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hACE1, 1'b0, 16'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 16'd0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, s1,       1'b1, 16'd1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0000, s2,       1'b1, 16'd2, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, s2,       1'b0, 16'd2, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 16'h0000, s3,       1'b1, 16'd3, 1'b0};

    for (int i = 0; i < 10; i++) begin
      ia.run_toggle = tbl[i].tgl;
      ia.step_req   = tbl[i].step;
      ia.load       = tbl[i].ld;
      ia.seed       = tbl[i].seed;
      if (tbl[i].pulse) push_adv(tbl[i].q, tbl[i].cnt);
      @(posedge clk); #1;
      idle_inputs();
      check($sformatf("row%0d_q", i), 32'(ia.lfsr_q), 32'(tbl[i].q));
      check($sformatf("row%0d_hex", i), 32'({ia.hex3, ia.hex2, ia.hex1, ia.hex0}), 32'(tbl[i].q));
      check($sformatf("row%0d_pulse", i), 32'(ia.step_pulse), 32'(tbl[i].pulse));
      check($sformatf("row%0d_cnt", i), 32'(ia.step_cnt), 32'(tbl[i].cnt));
      check($sformatf("row%0d_run", i), 32'(ia.running), 32'(tbl[i].run));
      check($sformatf("row%0d_pd", i), 32'(ia.period_done), 0);
    end

    // Auto stepping: advances land 4, 8 and 12 edges after the toggle edge, and step_req is ignored.
    e1 = model_next(s3);
    e2 = model_next(e1);
    e3 = model_next(e2);
    push_adv(e1, 16'd4);
    push_adv(e2, 16'd5);
    push_adv(e3, 16'd6);
    ia.run_toggle = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("auto_run_on", 32'(ia.running), 1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) ia.step_req = 1'b1;
      @(posedge clk); #1;
      ia.step_req = 1'b0;
      check($sformatf("auto_pulse_k%0d", k), 32'(ia.step_pulse), 32'(k % 4 == 0));
    end
    check("auto_q", 32'(ia.lfsr_q), 32'(e3));
    check("auto_cnt", 32'(ia.step_cnt), 32'd6);

    ia.run_toggle = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("auto_run_off", 32'(ia.running), 0);
    np = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ia.step_pulse) np++;
    end
    check("paused_no_pulse", 32'(np), 0);
    push_adv(model_next(e3), 16'd7);
    ia.step_req = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("resume_step_pulse", 32'(ia.step_pulse), 1);
    check("resume_step_q", 32'(ia.lfsr_q), 32'(model_next(e3)));

    // The reset lands on the edge where the prescaler would otherwise tick.
    ia.run_toggle = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    np = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ia.step_pulse) np++;
    end
    check("prereset_no_pulse", 32'(np), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_q", 32'(ia.lfsr_q), 32'h0000ACE1);
    check("midrst_run", 32'(ia.running), 0);
    check("midrst_cnt", 32'(ia.step_cnt), 0);
    check("midrst_pulse", 32'(ia.step_pulse), 0);
    check("midrst_pd", 32'(ia.period_done), 0);
    rst = 1'b0;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ia.step_pulse || ia.period_done) np++;
    end
    check("postrst_no_pulse", 32'(np), 0);

    // Full period on instance B: load seed 1 and start running on the same edge.
    ib.load = 1'b1; ib.seed = 16'h0001; ib.run_toggle = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("period_load_q", 32'(ib.lfsr_q), 32'h1);
    check("period_run", 32'(ib.running), 1);
    miss = 0; model_err = 0; zero_seen = 0; rep = 0; pd_cnt = 0; pd_n = 0;
    cnt34 = 16'h0;
    prev = 16'h0001;
    seen[1] = 1'b1;
    for (int n = 1; n <= 65535; n++) begin
      @(posedge clk); #1;
      cur = ib.lfsr_q;
      if (ib.step_pulse !== 1'b1) miss++;
      if (cur !== model_next(prev)) model_err++;
      if (cur == 16'h0000) zero_seen++;
      if (!$isunknown(cur)) begin
        if (n < 65535 && seen[cur]) rep++;
        seen[cur] = 1'b1;
      end
      if (ib.period_done) begin
        pd_cnt++;
        pd_n = n;
      end
      if (n == 65534) cnt34 = ib.step_cnt;
      prev = cur;
    end
    check("period_missed_steps", 32'(miss), 0);
    check("period_model_err", 32'(model_err), 0);
    check("period_zero_state", 32'(zero_seen), 0);
    check("period_repeats", 32'(rep), 0);
    check("period_done_count", 32'(pd_cnt), 1);
    check("period_done_at", 32'(pd_n), 65535);
    check("period_final_q", 32'(ib.lfsr_q), 32'h1);
    check("period_final_cnt", 32'(ib.step_cnt), 0);
    check("period_cnt_before_wrap", 32'(cnt34), 32'd65534);
    ib.run_toggle = 1'b1;
    @(posedge clk); #1;
    idle_inputs();

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
